// File: rtl/match_window_counter_if.sv
// Report channel of the match window counter: one-entry valid/ready result slot
// carrying the window match count and its threshold alarm.
interface match_window_counter_if #(
  parameter int unsigned CNT_W = 8
);
  logic             rep_valid;
  logic             rep_ready;
  logic [CNT_W-1:0] rep_count;
  logic             rep_alarm;

  modport master (
    output rep_valid,
    output rep_count,
    output rep_alarm,
    input  rep_ready
  );

  modport slave (
    input  rep_valid,
    input  rep_count,
    input  rep_alarm,
    output rep_ready
  );
endinterface

// File: rtl/match_window_counter.sv
// Counts detector match pulses over back-to-back WINDOW-clock windows and
// publishes each window total through a one-entry valid/ready report slot.
module match_window_counter #(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned THRESH = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic y_in,
  input  logic ovr_clr,
  output logic overrun,
  output logic busy,
  match_window_counter_if.master rep
);

  localparam int unsigned WCNT_W = $clog2(WINDOW);
  localparam logic [WCNT_W-1:0] LAST = WCNT_W'(WINDOW - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] COUNT = 1'b1;

  logic [0:0]        r_state;
  logic [WCNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0]  r_evt;

  logic              w_win_end;
  logic              w_accept;
  logic              w_load;
  logic              w_drop;
  logic              w_alarm;
  logic [CNT_W-1:0]  w_final;

  // w_final folds in the current edge's pulse so the window-end edge counts it.
  always_comb begin
    w_final   = r_evt;
    if (y_in && (r_evt != '1)) begin
      w_final = r_evt + CNT_W'(1);
    end
    w_win_end = (r_state == COUNT) && enable && (r_wcnt == LAST);
    w_accept  = rep.rep_valid && rep.rep_ready;
    w_load    = w_win_end && (!rep.rep_valid || rep.rep_ready);
    w_drop    = w_win_end && rep.rep_valid && !rep.rep_ready;
    w_alarm   = (32'(w_final) >= THRESH);
  end

  assign busy = (r_state == COUNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_evt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wcnt <= '0;
          r_evt  <= '0;
          if (enable) begin
            r_state <= COUNT;
          end
        end
        default: begin
          if (!enable) begin
            r_state <= IDLE;
            r_wcnt  <= '0;
            r_evt   <= '0;
          end else if (r_wcnt == LAST) begin
            r_wcnt <= '0;
            r_evt  <= '0;
          end else begin
            r_wcnt <= r_wcnt + WCNT_W'(1);
            r_evt  <= w_final;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep.rep_valid <= 1'b0;
      rep.rep_count <= '0;
      rep.rep_alarm <= 1'b0;
    end else if (w_load) begin
      rep.rep_valid <= 1'b1;
      rep.rep_count <= w_final;
      rep.rep_alarm <= w_alarm;
    end else if (w_accept) begin
      rep.rep_valid <= 1'b0;
    end
  end

  // A drop on the same edge as ovr_clr leaves the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (w_drop) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule
